// File: rtl/lifo_pkg.sv
// Shared types for the LIFO stack: the signed data word and the decoded
// per-cycle operation used by the datapath and for bench logging.
package lifo_pkg;

    typedef logic signed [7:0] data8_t;

    localparam int DEF_DEPTH = 16;

    typedef enum {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP, OP_FLUSH} lifo_op_e;

endpackage

// File: rtl/lifo_stack_if.sv
// Producer/consumer side of the LIFO stack: requests, pop result and status.
// The master modport is the producer/consumer, the slave modport is the stack.
interface lifo_stack_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     flush;
    logic                     push;
    logic signed [DATA_W-1:0] push_data;
    logic                     pop;
    logic                     clr_err;
    logic signed [DATA_W-1:0] pop_data;
    logic                     pop_valid;
    logic signed [DATA_W-1:0] top_data;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output flush, push, push_data, pop, clr_err,
        input  pop_data, pop_valid, top_data, count, full, empty, overflow, underflow
    );

    modport slave (
        input  flush, push, push_data, pop, clr_err,
        output pop_data, pop_valid, top_data, count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/lifo_mem.sv
// Stack storage: DEPTH x DATA_W register array with one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module lifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO with registered pop data, occupancy status and sticky
// overflow/underflow flags. The stack pointer is the occupancy count itself.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    lifo_stack_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);

    lifo_op_e                 op;
    logic [CNT_W-1:0]         count_q,     count_d;
    logic signed [DATA_W-1:0] pop_data_q,  pop_data_d;
    logic                     pop_valid_q, pop_valid_d;
    logic                     overflow_q,  overflow_d;
    logic                     underflow_q, underflow_d;

    logic                     full;
    logic                     empty;
    logic [AW-1:0]            sp_addr;
    logic [AW-1:0]            sp_m1;
    logic                     mem_we;
    logic [AW-1:0]            mem_waddr;
    logic signed [DATA_W-1:0] mem_rdata;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign sp_addr = count_q[AW-1:0];
    assign sp_m1   = AW'(count_q - CNT_W'(1));

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (bus.push_data),
        .raddr  (sp_m1),
        .rdata  (mem_rdata)
    );

    always_comb begin
        op = OP_IDLE;
        if (bus.flush) begin
            op = OP_FLUSH;
        end else if (bus.push && bus.pop) begin
            op = OP_SWAP;
        end else if (bus.push) begin
            op = OP_PUSH;
        end else if (bus.pop) begin
            op = OP_POP;
        end
    end

    // A fresh error in the same cycle as clr_err wins because it is applied after the clear.
    always_comb begin
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q  & ~bus.clr_err;
        underflow_d = underflow_q & ~bus.clr_err;
        mem_we      = 1'b0;
        mem_waddr   = sp_addr;
        case (op)
            OP_FLUSH: begin
                count_d = '0;
            end
            OP_SWAP: begin
                mem_we = 1'b1;
                if (!empty) begin
                    pop_data_d  = mem_rdata;
                    pop_valid_d = 1'b1;
                    mem_waddr   = sp_m1;
                end else begin
                    count_d     = CNT_W'(1);
                    underflow_d = 1'b1;
                end
            end
            OP_PUSH: begin
                if (!full) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    pop_data_d  = mem_rdata;
                    pop_valid_d = 1'b1;
                    count_d     = count_q - CNT_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.top_data  = empty ? '0 : mem_rdata;

endmodule
